// File: rtl/gray_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | gray_pkg : Gray/binary conversion helpers and accumulator state type  |
// | Revision : 1.0                                                        |
// +-----------------------------------------------------------------------+
package gray_pkg;

    localparam int GRAY_MAX_W = 64;

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } gacc_state_t;

    // Bits above w must be zero on entry; w selects the active MSB.
    function automatic logic [GRAY_MAX_W-1:0] gray2bin(
        input logic [GRAY_MAX_W-1:0] g,
        input int                    w
    );
        logic [GRAY_MAX_W-1:0] b;
        b        = '0;
        b[w-1]   = g[w-1];
        for (int i = GRAY_MAX_W-2; i >= 0; i--) begin
            if (i < w-1) begin
                b[i] = g[i] ^ b[i+1];
            end
        end
        return b;
    endfunction

    function automatic logic [GRAY_MAX_W-1:0] bin2gray(
        input logic [GRAY_MAX_W-1:0] b
    );
        return b ^ (b >> 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/gray_to_bin_conv.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | gray_to_bin_conv : combinational WIDTH-bit Gray to binary converter   |
// | Revision : 1.0                                                        |
// +-----------------------------------------------------------------------+
module gray_to_bin_conv
    import gray_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_gray,
    output logic [WIDTH-1:0] o_bin
);

    assign o_bin = WIDTH'(gray2bin(GRAY_MAX_W'(i_gray), WIDTH));

endmodule
`default_nettype wire

// File: rtl/gray_sum_accumulator.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | gray_sum_accumulator : frames Gray operands, emits Gray+binary sum    |
// | Revision : 1.0                                                        |
// +-----------------------------------------------------------------------+
module gray_sum_accumulator
    import gray_pkg::*;
#(
    parameter  int WIDTH     = 4,
    parameter  int COUNT_MAX = 8,
    localparam int SUM_W     = WIDTH + $clog2(COUNT_MAX),
    localparam int CNT_W     = $clog2(COUNT_MAX + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_gray,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SUM_W-1:0] out_gray_sum,
    output logic [SUM_W-1:0] out_bin_sum,
    output logic [CNT_W-1:0] out_count,
    output logic             out_overflow
);

    gacc_state_t      state_q, state_d;
    logic [SUM_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SUM_W-1:0] out_bin_q, out_bin_d;
    logic [SUM_W-1:0] out_gray_q, out_gray_d;
    logic [CNT_W-1:0] out_count_q, out_count_d;
    logic             out_overflow_q, out_overflow_d;

    logic [WIDTH-1:0] in_bin;
    logic [SUM_W-1:0] acc_sum;
    logic [CNT_W-1:0] cnt_inc;
    logic             frame_full;
    logic             accept;
    logic             close;

    gray_to_bin_conv #(
        .WIDTH (WIDTH)
    ) u_in_conv (
        .i_gray (in_gray),
        .o_bin  (in_bin)
    );

    assign acc_sum    = acc_q + SUM_W'(in_bin);
    assign cnt_inc    = cnt_q + CNT_W'(1);
    assign frame_full = (cnt_inc == CNT_W'(COUNT_MAX));
    assign accept     = in_valid && in_ready;
    assign close      = accept && (in_last || frame_full);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACCUM;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ACCUM:   if (close)     state_d = HOLD;
            HOLD:    if (out_ready) state_d = ACCUM;
            default:                state_d = ACCUM;
        endcase
    end

    // Handshake outputs are pure state decodes, so no input reaches them combinationally.
    always_comb begin
        in_ready  = (state_q == ACCUM);
        out_valid = (state_q == HOLD);
    end

    always_comb begin
        acc_d          = acc_q;
        cnt_d          = cnt_q;
        out_bin_d      = out_bin_q;
        out_gray_d     = out_gray_q;
        out_count_d    = out_count_q;
        out_overflow_d = out_overflow_q;
        if (accept) begin
            acc_d = acc_sum;
            cnt_d = cnt_inc;
        end
        if (close) begin
            acc_d          = '0;
            cnt_d          = '0;
            out_bin_d      = acc_sum;
            out_gray_d     = SUM_W'(bin2gray(GRAY_MAX_W'(acc_sum)));
            out_count_d    = cnt_inc;
            out_overflow_d = frame_full && !in_last;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q          <= '0;
            cnt_q          <= '0;
            out_bin_q      <= '0;
            out_gray_q     <= '0;
            out_count_q    <= '0;
            out_overflow_q <= 1'b0;
        end else begin
            acc_q          <= acc_d;
            cnt_q          <= cnt_d;
            out_bin_q      <= out_bin_d;
            out_gray_q     <= out_gray_d;
            out_count_q    <= out_count_d;
            out_overflow_q <= out_overflow_d;
        end
    end

    assign out_bin_sum  = out_bin_q;
    assign out_gray_sum = out_gray_q;
    assign out_count    = out_count_q;
    assign out_overflow = out_overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_gray_sum_accumulator.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_gray_sum_accumulator : directed self-checking bench                |
// | Revision : 1.0                                                        |
// +-----------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_gray_sum_accumulator;

    localparam int WIDTH     = 4;
    localparam int COUNT_MAX = 8;
    localparam int SUM_W     = 7;
    localparam int CNT_W     = 4;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_gray;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [SUM_W-1:0] out_gray_sum;
    logic [SUM_W-1:0] out_bin_sum;
    logic [CNT_W-1:0] out_count;
    logic             out_overflow;

    int checks = 0;
    int errors = 0;

    gray_sum_accumulator #(
        .WIDTH     (WIDTH),
        .COUNT_MAX (COUNT_MAX)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_gray      (in_gray),
        .in_last      (in_last),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_gray_sum (out_gray_sum),
        .out_bin_sum  (out_bin_sum),
        .out_count    (out_count),
        .out_overflow (out_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drives one beat and returns just after the edge that accepted it.
    task automatic beat(input logic [WIDTH-1:0] g, input logic last);
        int n;
        in_valid = 1'b1;
        in_gray  = g;
        in_last  = last;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) check_eq("ready_timeout", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic check_result(input string tag, input int bin, input int gray,
                                input int cnt, input int ovf);
        check_eq({tag, "_valid"}, 32'(out_valid),    32'd1);
        check_eq({tag, "_rdy"},   32'(in_ready),     32'd0);
        check_eq({tag, "_bin"},   32'(out_bin_sum),  32'(bin));
        check_eq({tag, "_gray"},  32'(out_gray_sum), 32'(gray));
        check_eq({tag, "_cnt"},   32'(out_count),    32'(cnt));
        check_eq({tag, "_ovf"},   32'(out_overflow), 32'(ovf));
    endtask

    task automatic take_result(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_eq({tag, "_drop_valid"}, 32'(out_valid), 32'd0);
        check_eq({tag, "_ready_back"}, 32'(in_ready),  32'd1);
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, "_valid"}, 32'(out_valid),    32'd0);
        check_eq({tag, "_rdy"},   32'(in_ready),     32'd1);
        check_eq({tag, "_bin"},   32'(out_bin_sum),  32'd0);
        check_eq({tag, "_gray"},  32'(out_gray_sum), 32'd0);
        check_eq({tag, "_cnt"},   32'(out_count),    32'd0);
        check_eq({tag, "_ovf"},   32'(out_overflow), 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_gray   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_zero("post_reset");

        // 4 + 1 = 5
        beat(4'b0110, 1'b0);
        check_eq("t1_mid_valid", 32'(out_valid), 32'd0);
        beat(4'b0001, 1'b1);
        check_result("t1", 5, 7'b0000111, 2, 0);
        take_result("t1");

        // Eight beats of 15 with no in_last force-close the frame
        for (int i = 0; i < 8; i++) beat(4'b1000, 1'b0);
        check_result("t2", 120, 7'b1000100, 8, 1);
        take_result("t2");
        beat(4'b0001, 1'b1);
        check_result("t2_next", 1, 7'b0000001, 1, 0);
        take_result("t2_next");

        // Back-pressure: result must hold while out_ready stays low
        beat(4'b1000, 1'b1);
        for (int i = 0; i < 5; i++) begin
            check_result($sformatf("t3_hold%0d", i), 15, 7'b0001000, 1, 0);
            @(posedge clk); #1;
        end
        take_result("t3");

        // in_last on the COUNT_MAX-th beat is not an overflow
        for (int i = 0; i < 8; i++) beat(4'b0001, (i == 7) ? 1'b1 : 1'b0);
        check_result("t4", 8, 7'b0001100, 8, 0);
        take_result("t4");

        // Reset mid-frame discards partial sum
        for (int i = 0; i < 3; i++) beat(4'b0001, 1'b0);
        rst_n = 1'b0;
        #2;
        check_zero("t5_rst_mid");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_zero("t5_rel_mid");

        // Reset while holding a result discards it
        beat(4'b0111, 1'b1);
        check_result("t5_pre", 5, 7'b0000111, 1, 0);
        rst_n = 1'b0;
        #2;
        check_zero("t5_rst_hold");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_zero("t5_rel_hold");
        beat(4'b0011, 1'b1);
        check_result("t5", 2, 7'b0000011, 1, 0);
        take_result("t5");

        // Idle gaps between beats must not disturb the accumulator
        for (int i = 0; i < 3; i++) begin
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk); #1;
                check_eq("t6_gap_valid", 32'(out_valid), 32'd0);
            end
            beat(4'b0010, (i == 2) ? 1'b1 : 1'b0);
        end
        check_result("t6", 9, 7'b0001101, 3, 0);
        take_result("t6");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
